fvalue_bank: RTL and testbench
==============================

FVALUE_BANK -- requirements
Module: fvalue_bank

Interface
REQ-001 SHALL have parameter N_REGS, default 4, number of preset field registers (1..16).
REQ-002 SHALL have parameter FIELD_W, default 4, width of each field (1..32).
REQ-003 SHALL have parameter PRESET, default all-ones {N_REGS*FIELD_W}, concatenated preset values; register i uses bits [i*FIELD_W +: FIELD_W].
REQ-004 SHALL have ports: clk_i in 1, the single clock; rst_n_i in 1, reset, asynchronous, active-low.
REQ-005 SHALL have Wishbone slave ports: wb_cyc_i in 1; wb_stb_i in 1; wb_adr_i in 4, word address; wb_sel_i in 4, byte lanes; wb_we_i in 1; wb_dat_i in 32; wb_ack_o out 1; wb_err_o out 1; wb_rty_o out 1; wb_stall_o out 1; wb_dat_o out 32.
REQ-006 SHALL have fields_o out N_REGS*FIELD_W, the current field values, register i at [i*FIELD_W +: FIELD_W].
REQ-007 SHALL have wr_strobe_o out N_REGS, a one-cycle pulse per register on each accepted write.

Function
REQ-008 SHALL accept a request when wb_cyc_i & wb_stb_i and no same-direction transaction is in progress; the in-progress flag clears on that transaction's ack/err.
REQ-009 SHALL decode addresses 0..N_REGS-1 as field registers; every other address is out of range.
REQ-010 SHALL register accepted writes (request, data, address, sel) into one pipeline stage; the target register updates at the clock edge ending the cycle after acceptance.
REQ-011 SHALL assert wb_ack_o for exactly one cycle, the cycle after acceptance, for in-range reads and writes.
REQ-012 SHALL assert wb_err_o instead of wb_ack_o, same timing, for out-of-range accesses; out-of-range writes change no state, and out-of-range reads return 0.
REQ-013 SHALL update field bit b only when wb_sel_i[b/8] was set in the write; with all sel bits clear, the write acks and no bit changes.
REQ-014 SHALL pulse wr_strobe_o[i] in the ack cycle of an in-range write to register i, regardless of sel.
REQ-015 SHALL return read data on wb_dat_o in the ack cycle: field in bits [FIELD_W-1:0], upper bits 0.
REQ-016 SHALL drive wb_stall_o = ~(ack|err) & wb_cyc_i & wb_stb_i, and tie wb_rty_o to 0.
REQ-017 SHALL reflect an updated field on fields_o in the cycle after the update edge, with no extra latency.
REQ-018 SHALL handle a read and a write accepted in the same cycle independently, each with its own ack.

Reset
REQ-019 SHALL, while rst_n_i = 0, immediately and asynchronously force every field to its PRESET value; wb_dat_o, wb_ack_o, wb_err_o, wr_strobe_o and the pipeline stage to 0; and in-progress flags to 0.
REQ-020 SHALL also initialise the field registers to PRESET at power-up, without a reset.
REQ-021 SHALL drop a transaction in progress when reset is asserted mid-transaction: it is never acked and no field changes.

Configuration
REQ-022 SHALL, with macro FVALUE_BANK_LOCK_EN defined, add a lock register at address N_REGS:
- bit0 is writable and readable, with reset value 0;
- while bit0 = 1, field writes are acked but change no field and pulse no strobe;
- address N_REGS+1 and above stay out of range.
REQ-023 SHALL, without FVALUE_BANK_LOCK_EN, have no lock register, and address N_REGS is out of range.

Verification
REQ-024 SHALL verify reset: with defaults, after reset read addresses 0..3 -> 0x0000000F each, fields_o = 16'hFFFF, 1-cycle ack.
REQ-025 SHALL verify a write: write addr 2 data 0x5 sel 4'b0001 -> ack next cycle; wr_strobe_o = 4'b0100 for one cycle; fields_o[11:8] = 4'h5; read addr 2 -> 0x5.
REQ-026 SHALL verify sel masking: FIELD_W=16, write addr 1 data 0xABCD sel 4'b0010 -> field1 = 0xABFF.
REQ-027 SHALL verify out of range: read addr 7 -> wb_err_o pulse, no ack, data 0; write addr 7 -> err, fields_o unchanged.
REQ-028 SHALL verify reset mid-write: assert rst_n_i in the ack cycle of a write to addr 0 with data 0x3 -> field0 = 0xF, no ack after reset release.
REQ-029 SHALL verify the lock (with FVALUE_BANK_LOCK_EN): write addr 4 data 1, then write addr 0 data 0x0 -> ack, field0 stays 0xF; write addr 4 data 0 -> subsequent write takes effect.

Source files
------------

// File: rtl/fvalue_bank.sv
// ---------------------------------------------------------------------------
// fvalue_bank
//
// Purpose:
//   A small bank of N_REGS preset field registers, each FIELD_W bits wide,
//   behind a Wishbone slave port. Reads return the field zero-extended to
//   32 bits. Writes are byte-lane masked and pass through one pipeline stage
//   before they land in the field register. Every accepted in-range write
//   pulses the strobe of its register.
//
// Optional feature (compile-time macro FVALUE_BANK_LOCK_EN):
//   Adds a lock register at address N_REGS. Bit 0 is readable and writable
//   and resets to 0. While it is set, field writes are still acked but they
//   change nothing and pulse no strobe. Without the macro, address N_REGS
//   is out of range like any other unused address.
//
// Ports:
//   clk_i        single clock
//   rst_n_i      asynchronous, active-low reset
//   wb_cyc_i     Wishbone cycle
//   wb_stb_i     Wishbone strobe
//   wb_adr_i     word address (4 bits)
//   wb_sel_i     byte-lane selects
//   wb_we_i      write enable
//   wb_dat_i     write data
//   wb_ack_o     one-cycle ack, the cycle after acceptance (in range)
//   wb_err_o     one-cycle error, same timing (out of range)
//   wb_rty_o     always 0
//   wb_stall_o   ~(ack|err) & cyc & stb
//   wb_dat_o     read data, valid in the ack/err cycle
//   fields_o     current field values; register i at [i*FIELD_W +: FIELD_W]
//   wr_strobe_o  one-cycle pulse per register, in the ack cycle of a write
// ---------------------------------------------------------------------------
module fvalue_bank #(
  parameter int                         N_REGS  = 4,
  parameter int                         FIELD_W = 4,
  parameter logic [N_REGS*FIELD_W-1:0]  PRESET  = {(N_REGS*FIELD_W){1'b1}}
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic [3:0]                 wb_adr_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic                       wb_we_i,
  input  logic [31:0]                wb_dat_i,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_rty_o,
  output logic                       wb_stall_o,
  output logic [31:0]                wb_dat_o,
  output logic [N_REGS*FIELD_W-1:0]  fields_o,
  output logic [N_REGS-1:0]          wr_strobe_o
);

  localparam int         FW      = N_REGS * FIELD_W;
  // Addresses are widened by one bit so that N_REGS = 16 (the lock address
  // in that case) is representable without wrapping onto address 0.
  localparam logic [4:0] NREGS_A = 5'(N_REGS);

  // Request decode
  logic [4:0]          w_adr;
  logic [4:0]          w_wr_adr;
  logic                w_req;
  logic                w_acc_rd;
  logic                w_acc_wr;
  logic                w_is_field;
  logic                w_is_lock;
  logic                w_in_range;
  logic                w_locked;
  logic [31:0]         w_lock_word;
  logic [FIELD_W-1:0]  w_rd_field;
  logic [31:0]         w_rd_data;
  logic [FIELD_W-1:0]  w_bit_mask;
  logic [FW-1:0]       w_fields_next;
  logic [N_REGS-1:0]   w_strobe_next;
  logic                w_unused;

  // State
  logic                r_rd_busy;
  logic                r_wr_busy;
  logic                r_ack;
  logic                r_err;
  logic [31:0]         r_dat;
  logic [N_REGS-1:0]   r_strobe;
  logic                r_wr_vld;
  logic [3:0]          r_wr_adr;
  logic [3:0]          r_wr_sel;
  logic [31:0]         r_wr_dat;
  // Power-up value comes from the declaration, so the fields hold PRESET
  // even if the reset is never pulsed.
  logic [FW-1:0]       r_fields = PRESET;

  assign w_adr    = {1'b0, wb_adr_i};
  assign w_wr_adr = {1'b0, r_wr_adr};
  assign w_req    = wb_cyc_i & wb_stb_i;

  // Reads and writes track their own in-progress flag, so a read can be
  // accepted while a write is still acking and vice versa.
  assign w_acc_rd = w_req & ~wb_we_i & ~r_rd_busy;
  assign w_acc_wr = w_req &  wb_we_i & ~r_wr_busy;

  assign w_is_field = (w_adr < NREGS_A);
  assign w_in_range = w_is_field | w_is_lock;

`ifdef FVALUE_BANK_LOCK_EN
  logic r_lock;

  assign w_is_lock   = (w_adr == NREGS_A);
  assign w_locked    = r_lock;
  assign w_lock_word = {31'd0, r_lock};

  // The lock bit sits in byte lane 0 and follows the same lane masking as
  // the fields.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock <= 1'b0;
    end else if (r_wr_vld && (w_wr_adr == NREGS_A) && r_wr_sel[0]) begin
      r_lock <= r_wr_dat[0];
    end
  end
`else
  assign w_is_lock   = 1'b0;
  assign w_locked    = 1'b0;
  assign w_lock_word = 32'd0;
`endif

  // Read mux over the field registers
  always_comb begin
    w_rd_field = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (w_adr == 5'(i)) begin
        w_rd_field = r_fields[i*FIELD_W +: FIELD_W];
      end
    end
  end

  assign w_rd_data = w_is_field ? 32'(w_rd_field) :
                     w_is_lock  ? w_lock_word     : 32'd0;

  // Field bit b is governed by byte lane b/8 of the registered write.
  genvar gi;
  generate
    for (gi = 0; gi < FIELD_W; gi++) begin : g_mask
      assign w_bit_mask[gi] = r_wr_sel[gi/8];
    end

    for (gi = 0; gi < N_REGS; gi++) begin : g_field
      logic w_hit;
      assign w_hit = (w_wr_adr == 5'(gi));
      assign w_fields_next[gi*FIELD_W +: FIELD_W] =
        w_hit ? ((r_fields[gi*FIELD_W +: FIELD_W] & ~w_bit_mask) |
                 (r_wr_dat[FIELD_W-1:0] & w_bit_mask))
              : r_fields[gi*FIELD_W +: FIELD_W];
      // The strobe ignores sel: a write with no lanes still counts.
      assign w_strobe_next[gi] = w_acc_wr & ~w_locked & (w_adr == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_busy <= 1'b0;
      r_wr_busy <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= 32'd0;
      r_strobe  <= '0;
      r_wr_vld  <= 1'b0;
      r_wr_adr  <= 4'd0;
      r_wr_sel  <= 4'd0;
      r_wr_dat  <= 32'd0;
      r_fields  <= PRESET;
    end else begin
      // The ack/err always arrives the cycle after acceptance, so a busy
      // flag is high exactly during that response cycle and clears with it.
      r_rd_busy <= w_acc_rd;
      r_wr_busy <= w_acc_wr;
      r_ack     <= (w_acc_rd | w_acc_wr) & w_in_range;
      r_err     <= (w_acc_rd | w_acc_wr) & ~w_in_range;
      r_dat     <= w_acc_rd ? w_rd_data : 32'd0;
      r_strobe  <= w_strobe_next;

      // Write pipeline stage
      r_wr_vld <= w_acc_wr;
      if (w_acc_wr) begin
        r_wr_adr <= wb_adr_i;
        r_wr_sel <= wb_sel_i;
        r_wr_dat <= wb_dat_i;
      end

      // Commit at the edge that ends the ack cycle. Out-of-range and lock
      // addresses hit no field, so w_fields_next equals r_fields for them.
      // Writes are serialised, so the lock cannot change between the
      // acceptance of a field write and its commit.
      if (r_wr_vld && !w_locked) begin
        r_fields <= w_fields_next;
      end
    end
  end

  // Data bits above FIELD_W and unused byte lanes are intentionally ignored.
  assign w_unused = ^{r_wr_dat, r_wr_sel};

  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign wb_rty_o    = 1'b0;
  assign wb_stall_o  = ~(r_ack | r_err) & wb_cyc_i & wb_stb_i;
  assign wb_dat_o    = r_dat;
  assign fields_o    = r_fields;
  assign wr_strobe_o = r_strobe;

endmodule

// File: tb/tb_fvalue_bank.sv
// ---------------------------------------------------------------------------
// tb_fvalue_bank
//
// Drives fvalue_bank (defaults N_REGS=4, FIELD_W=4) with directed and random
// Wishbone traffic and compares every output each cycle with a transaction-
// level model of the register bank. A second instance with FIELD_W=16
// checks byte-lane masking on a wider field.
// ---------------------------------------------------------------------------
module tb_fvalue_bank;

  localparam int N = 4;
  localparam int W = 4;
`ifdef FVALUE_BANK_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT signals
  logic          cyc, stb, we;
  logic [3:0]    adr, sel;
  logic [31:0]   dat;
  logic          ack, err, rty, stall;
  logic [31:0]   dat_o;
  logic [N*W-1:0] fields;
  logic [N-1:0]  strobe;

  // Wide DUT signals
  logic          b_cyc, b_stb, b_we;
  logic [3:0]    b_adr, b_sel;
  logic [31:0]   b_dat;
  logic          b_ack, b_err, b_rty, b_stall;
  logic [31:0]   b_dat_o;
  logic [N*16-1:0] b_fields;
  logic [N-1:0]  b_strobe;

  fvalue_bank #(.N_REGS(N), .FIELD_W(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr), .wb_sel_i(sel),
    .wb_we_i(we), .wb_dat_i(dat),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_stall_o(stall),
    .wb_dat_o(dat_o), .fields_o(fields), .wr_strobe_o(strobe)
  );

  fvalue_bank #(.N_REGS(N), .FIELD_W(16)) dut16 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_adr_i(b_adr), .wb_sel_i(b_sel),
    .wb_we_i(b_we), .wb_dat_i(b_dat),
    .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_rty_o(b_rty), .wb_stall_o(b_stall),
    .wb_dat_o(b_dat_o), .fields_o(b_fields), .wr_strobe_o(b_strobe)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  // Transaction-level model of the bank
  logic [W-1:0] m_field [N];
  logic         m_lock;
  logic         m_busy_rd, m_busy_wr;
  logic         m_pend;
  logic [3:0]   m_pend_adr, m_pend_sel;
  logic [31:0]  m_pend_dat;
  logic         e_ack, e_err;
  logic [31:0]  e_dat;
  logic [N-1:0] e_strobe;

  function automatic logic [N*W-1:0] m_vec();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = m_field[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_field[i] = '1;
    m_lock = 1'b0; m_busy_rd = 1'b0; m_busy_wr = 1'b0; m_pend = 1'b0;
    m_pend_adr = '0; m_pend_sel = '0; m_pend_dat = '0;
    e_ack = 1'b0; e_err = 1'b0; e_dat = '0; e_strobe = '0;
  endtask

  // One clock of traffic: drive at the negedge, predict, check at next negedge.
  task automatic step(input logic c, input logic s, input logic w,
                      input logic [3:0] a, input logic [3:0] sl, input logic [31:0] d);
    logic acc_rd, acc_wr, in_field, in_lock;
    logic [31:0] rd;
    cyc = c; stb = s; we = w; adr = a; sel = sl; dat = d;
    #1;
    chk("stall", stall, !(e_ack || e_err) && c && s);

    acc_rd   = c && s && !w && !m_busy_rd;
    acc_wr   = c && s &&  w && !m_busy_wr;
    in_field = (a < N);
    in_lock  = LOCK && (a == N);

    // Read sees the bank before this edge's write commit.
    rd = 32'd0;
    if (acc_rd && in_field) rd = 32'(m_field[a]);
    if (acc_rd && in_lock)  rd = 32'(m_lock);

    e_strobe = '0;
    if (acc_wr && in_field && !m_lock) e_strobe[a[1:0]] = 1'b1;

    // The write accepted last cycle lands at this edge.
    if (m_pend) begin
      if (m_pend_adr < N) begin
        if (!m_lock)
          for (int b = 0; b < W; b++)
            if (m_pend_sel[b/8]) m_field[m_pend_adr][b] = m_pend_dat[b];
      end else if (LOCK && m_pend_adr == N && m_pend_sel[0]) begin
        m_lock = m_pend_dat[0];
      end
    end
    m_pend = acc_wr;
    if (acc_wr) begin m_pend_adr = a; m_pend_sel = sl; m_pend_dat = d; end

    e_ack = (acc_rd || acc_wr) && (in_field || in_lock);
    e_err = (acc_rd || acc_wr) && !(in_field || in_lock);
    e_dat = rd;
    m_busy_rd = acc_rd;   // flag lives until its ack, which is next cycle
    m_busy_wr = acc_wr;

    @(negedge clk);
    chk("ack", ack, e_ack);
    chk("err", err, e_err);
    chk("rty", rty, 1'b0);
    chk("strobe", strobe, e_strobe);
    chk("fields", fields, m_vec());
    if (e_ack || e_err) chk("rdata", dat_o, e_dat);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
  endtask

  initial begin
    cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; dat = 0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = 0; b_sel = 0; b_dat = 0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_fields", fields, 16'hFFFF);
    chk("rst_ack", ack, 1'b0);
    chk("rst_strobe", strobe, 4'h0);
    chk("rst_dat", dat_o, 32'h0);
    rst_n = 1'b1;

    // Byte-lane masking on the 16-bit instance
    b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 4'd1; b_sel = 4'b0010; b_dat = 32'hABCD;
    @(negedge clk);
    chk("w16_ack", b_ack, 1'b1);
    chk("w16_err", b_err, 1'b0);
    b_cyc = 0; b_stb = 0; b_we = 0;
    @(negedge clk);
    chk("w16_field1", b_fields[31:16], 16'hABFF);
    chk("w16_field0", b_fields[15:0], 16'hFFFF);

    // Reset values read back
    for (int i = 0; i < N; i++) begin
      step(1, 1, 0, 4'(i), 4'hF, 32'd0);
      chk("lit_rst_rd", dat_o, 32'h0000000F);
      chk("lit_rst_rd_ack", ack, 1'b1);
      idle();
      chk("lit_rst_ack_1cyc", ack, 1'b0);
    end

    // Write addr 2
    step(1, 1, 1, 4'd2, 4'b0001, 32'h5);
    chk("lit_wr_ack", ack, 1'b1);
    chk("lit_wr_strobe", strobe, 4'b0100);
    idle();
    chk("lit_wr_strobe_off", strobe, 4'b0000);
    chk("lit_wr_field2", fields[11:8], 4'h5);
    step(1, 1, 0, 4'd2, 4'hF, 32'd0);
    chk("lit_rd2", dat_o, 32'h5);
    idle();

    // All lanes off: acks and strobes, no change
    step(1, 1, 1, 4'd1, 4'b0000, 32'h0);
    chk("lit_sel0_ack", ack, 1'b1);
    chk("lit_sel0_strobe", strobe, 4'b0010);
    idle(); idle();
    chk("lit_sel0_fields", fields, 16'hF5FF);

    // Out of range
    step(1, 1, 0, 4'd7, 4'hF, 32'd0);
    chk("lit_oor_rd_err", err, 1'b1);
    chk("lit_oor_rd_ack", ack, 1'b0);
    chk("lit_oor_rd_dat", dat_o, 32'h0);
    idle();
    step(1, 1, 1, 4'd7, 4'hF, 32'h0);
    chk("lit_oor_wr_err", err, 1'b1);
    idle(); idle();
    chk("lit_oor_wr_fields", fields, 16'hF5FF);

`ifdef FVALUE_BANK_LOCK_EN
    step(1, 1, 1, 4'd4, 4'hF, 32'h1);
    chk("lit_lock_wr_ack", ack, 1'b1);
    idle();
    step(1, 1, 1, 4'd0, 4'hF, 32'h0);
    chk("lit_locked_ack", ack, 1'b1);
    chk("lit_locked_strobe", strobe, 4'b0000);
    idle(); idle();
    chk("lit_locked_field0", fields[3:0], 4'hF);
    step(1, 1, 0, 4'd4, 4'hF, 32'd0);
    chk("lit_lock_rd", dat_o, 32'h1);
    idle();
    step(1, 1, 0, 4'd5, 4'hF, 32'd0);
    chk("lit_lock_oor5", err, 1'b1);
    idle();
    step(1, 1, 1, 4'd4, 4'hF, 32'h0);
    idle();
    step(1, 1, 1, 4'd0, 4'hF, 32'h0);
    idle(); idle();
    chk("lit_unlocked_field0", fields[3:0], 4'h0);
`else
    step(1, 1, 0, 4'd4, 4'hF, 32'd0);
    chk("lit_addr4_err", err, 1'b1);
    idle();
`endif

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 8) != 0, ($urandom % 4) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 7)), 4'($urandom), $urandom);
    end

    // Reset in the ack cycle of a write
    idle(); idle();
    step(1, 1, 1, 4'd0, 4'hF, 32'h3);
    chk("lit_midrst_ack_before", ack, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("lit_midrst_fields", fields, 16'hFFFF);
    chk("lit_midrst_ack", ack, 1'b0);
    m_reset();
    cyc = 0; stb = 0; we = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(); idle(); idle();
    chk("lit_midrst_field0", fields[3:0], 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
